// File: rtl/cpu_program_loader.sv
// cpu_program_loader: host-side loader and run monitor for the 16-bit CPU.
// It streams program words into instruction memory from address 0. It then
// pulses cpu_start and counts retired instructions until the run completes
// or stalls.
//
// Stream handshake: a word transfers on a rising clk edge where
// prog_valid && prog_ready. prog_ready is registered and depends only on the
// loader state, never on prog_valid. prog_data/prog_last are ignored
// whenever prog_valid is low.
module cpu_program_loader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_start,
  input  logic              cpu_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   retired,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   words;
  logic              prev_ready;
  logic [CNT_W-1:0]  idle_cnt;
  logic              ready_rise;

  assign state_dbg  = state;
  assign ready_rise = cpu_ready && !prev_ready;

  // Loader FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      prog_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      retired    <= '0;
      ptr        <= '0;
      words      <= '0;
      prev_ready <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_req) begin
            state      <= S_LOAD;
            prog_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            retired    <= '0;
            words      <= '0;
            ptr        <= '0;
          end
        end
        S_LOAD: begin
          if (prog_valid && prog_ready) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= prog_data;
            ptr       <= ptr + 1'b1;
            words     <= words + 1'b1;
            if (prog_last) begin
              state      <= S_START;
              prog_ready <= 1'b0;
            end else if (ptr == PTR_MAX) begin
              // Memory is full and the program has not ended: keep the word
              // just written, refuse to wrap over address 0.
              state      <= S_ERR;
              prog_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end
          end
        end
        S_START: begin
          cpu_start <= 1'b1;
          // Seed the edge detector with the current level so a ready line
          // that is already high when the run begins is not counted.
          prev_ready <= cpu_ready;
          idle_cnt   <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          prev_ready <= cpu_ready;
          // An edge wins over a timeout landing on the same cycle.
          if (ready_rise) begin
            idle_cnt <= '0;
            retired  <= retired + 1'b1;
            if ((retired + 1'b1) == words) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state <= S_ERR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
